// File: rtl/aes_spi_frontend.sv
// aes_spi_frontend: SPI slave front end for the AES core.
// Shifts in a 256-bit key+plaintext frame, starts the core,
// then returns the cyphertext on the following frame.
//
// Ports
//   clk, reset        system clock, synchronous active-high reset
//   i_sck, i_sdi      SPI clock / data in (async, mode 0, MSB first)
//   i_cs_n            SPI chip select, active low (async)
//   o_sdo             SPI data out, MSB first
//   o_aes_load        one-cycle start pulse to the AES core
//   o_aes_key         128-bit key, stable from load until next frame
//   o_aes_plaintext   128-bit plaintext, held like the key
//   i_aes_done        completion strobe from the AES core
//   i_aes_cyphertext  128-bit result, valid with i_aes_done
//   o_ready           cyphertext latched and available for readout
//   o_err             sticky frame-length / timeout error
module aes_spi_frontend #(
  parameter int SYNC_STAGES = 2,
  parameter int FRAME_BITS  = 256,
  parameter int MAX_WAIT    = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_sck,
  input  logic         i_sdi,
  input  logic         i_cs_n,
  output logic         o_sdo,
  output logic         o_aes_load,
  output logic [127:0] o_aes_key,
  output logic [127:0] o_aes_plaintext,
  input  logic         i_aes_done,
  input  logic [127:0] i_aes_cyphertext,
  output logic         o_ready,
  output logic         o_err
);

  localparam int CNT_W  = $clog2(FRAME_BITS) + 1;
  localparam int WAIT_W = $clog2(MAX_WAIT);

  localparam logic [CNT_W-1:0] FRAME_CNT =
    CNT_W'(FRAME_BITS);

  // The counter is cleared in LOAD and the WAIT cycle that
  // sees this value raises err, which lands exactly MAX_WAIT
  // cycles after the aes_load cycle.
  localparam logic [WAIT_W-1:0] WAIT_LAST =
    WAIT_W'(MAX_WAIT - 2);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_LOAD,
    S_WAIT
  } state_t;

  // Synchronizers
  logic [SYNC_STAGES-1:0] r_sck_sync;
  logic [SYNC_STAGES-1:0] r_sdi_sync;
  logic [SYNC_STAGES-1:0] r_cs_sync;

  logic w_sck;
  logic w_sdi;
  logic w_cs_n;

  assign w_sck  = r_sck_sync[SYNC_STAGES-1];
  assign w_sdi  = r_sdi_sync[SYNC_STAGES-1];
  assign w_cs_n = r_cs_sync[SYNC_STAGES-1];

  // Chip select resets low so that releasing reset in the
  // middle of a frame never fakes a cs_n falling edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sck_sync <= '0;
      r_sdi_sync <= '0;
      r_cs_sync  <= '0;
    end else begin
      r_sck_sync <= {r_sck_sync[SYNC_STAGES-2:0], i_sck};
      r_sdi_sync <= {r_sdi_sync[SYNC_STAGES-2:0], i_sdi};
      r_cs_sync  <= {r_cs_sync[SYNC_STAGES-2:0], i_cs_n};
    end
  end

  // Registered edge strobes; sdi is delayed alongside so the
  // sampled bit stays aligned with its sck rise strobe.
  logic r_sck_d;
  logic r_cs_d;
  logic r_sdi_d;
  logic r_sck_rise;
  logic r_sck_fall;
  logic r_cs_rise;
  logic r_cs_fall;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sck_d    <= 1'b0;
      r_cs_d     <= 1'b0;
      r_sdi_d    <= 1'b0;
      r_sck_rise <= 1'b0;
      r_sck_fall <= 1'b0;
      r_cs_rise  <= 1'b0;
      r_cs_fall  <= 1'b0;
    end else begin
      r_sck_d    <= w_sck;
      r_cs_d     <= w_cs_n;
      r_sdi_d    <= w_sdi;
      r_sck_rise <= w_sck & ~r_sck_d;
      r_sck_fall <= ~w_sck & r_sck_d;
      r_cs_rise  <= w_cs_n & ~r_cs_d;
      r_cs_fall  <= ~w_cs_n & r_cs_d;
    end
  end

  // State and datapath registers
  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [WAIT_W-1:0]  r_wait;
  logic [127:0]       r_key;
  logic [127:0]       r_pt;
  logic [127:0]       r_result;
  logic [127:0]       r_shift;
  logic               r_ready;
  logic               r_err;
  logic               w_frame_ok;
  logic               w_timeout;

  assign w_frame_ok = (r_cnt == FRAME_CNT);
  assign w_timeout  = (r_wait == WAIT_LAST);

  always_comb begin
    w_state_nxt = r_state;
    o_aes_load  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (r_cs_fall) begin
          w_state_nxt = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (r_cs_rise) begin
          w_state_nxt = w_frame_ok ? S_LOAD : S_IDLE;
        end
      end
      S_LOAD: begin
        o_aes_load  = 1'b1;
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        // done wins over a simultaneous timeout
        if (i_aes_done || w_timeout) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_wait   <= '0;
      r_key    <= '0;
      r_pt     <= '0;
      r_result <= '0;
      r_shift  <= '0;
      r_ready  <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      unique case (r_state)
        S_IDLE: begin
          if (r_cs_fall) begin
            r_cnt   <= '0;
            r_shift <= r_result;
            r_err   <= 1'b0;
          end
        end
        S_SHIFT: begin
          if (r_sck_rise) begin
            {r_key, r_pt} <= {r_key[126:0], r_pt, r_sdi_d};
            if (r_cnt != '1) begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          // readout copy only; r_result stays intact
          if (r_sck_fall) begin
            r_shift <= {r_shift[126:0], 1'b0};
          end
          if (r_cs_rise) begin
            if (w_frame_ok) begin
              r_ready <= 1'b0;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        S_LOAD: begin
          r_wait <= '0;
        end
        S_WAIT: begin
          if (i_aes_done) begin
            r_result <= i_aes_cyphertext;
            r_ready  <= 1'b1;
          end else if (w_timeout) begin
            r_err <= 1'b1;
          end else begin
            r_wait <= r_wait + 1'b1;
          end
        end
        default: begin
          r_cnt <= '0;
        end
      endcase
    end
  end

  assign o_sdo = (r_state == S_SHIFT) ? r_shift[127]
                                      : r_result[127];

  assign o_aes_key       = r_key;
  assign o_aes_plaintext = r_pt;
  assign o_ready         = r_ready;
  assign o_err           = r_err;

endmodule
